mmio_responder: RTL

- Responder end of the CPU data-memory/MMIO bus. Decodes each CPU access to either the data memory or a small MMIO register block.
- The MMIO block holds an 8-bit output FIFO toward a console device (valid/ready source), a 32-bit input mailbox from a device (valid/ready sink), and a free-running cycle counter.
- Sits between the single-cycle CPU and the data memory and peripheral side. Read data is combinational so loads complete in the same cycle.

---
 rtl/mmio_responder_if.sv | 30 +++
 rtl/mmio_responder.sv | 110 +++++++++++
 2 files changed

// File: rtl/mmio_responder_if.sv
// CPU data-side bus plus data-memory and peripheral handshakes seen by mmio_responder.
// slave is the responder view; master is the CPU/peripheral/bench view.
interface mmio_responder_if #(
  parameter int DM_AW = 8
);
  logic [31:0]      mem_addr;
  logic             mem_we;
  logic [31:0]      mem_din;
  logic [31:0]      mem_dout;
  logic [DM_AW-1:0] dm_addr;
  logic             dm_we;
  logic [31:0]      dm_din;
  logic [31:0]      dm_dout;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [31:0]      rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport slave (
    input  mem_addr, mem_we, mem_din, dm_dout, tx_ready, rx_data, rx_valid,
    output mem_dout, dm_addr, dm_we, dm_din, tx_data, tx_valid, rx_ready
  );

  modport master (
    output mem_addr, mem_we, mem_din, dm_dout, tx_ready, rx_data, rx_valid,
    input  mem_dout, dm_addr, dm_we, dm_din, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mmio_responder.sv
// Decodes CPU accesses into data memory or a small MMIO block: TX byte FIFO,
// RX word mailbox and a free-running cycle counter. Read data is combinational.
module mmio_responder #(
  parameter logic [31:0] MMIO_BASE  = 32'h0000_7F00,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DM_AW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  mmio_responder_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          in_valid_q, in_valid_d;
  logic [31:0]   in_data_q, in_data_d;
  logic [31:0]   cycle_q, cycle_d;

  logic          hit, wr, full, empty;
  logic          push, push_ok, pop, stat_wr, ack_wr, cyc_wr, capture;
  logic [7:0]    off, cnt8;
  logic [31:0]   rd_data;

  assign hit     = (bus.mem_addr[31:8] == MMIO_BASE[31:8]);
  assign off     = bus.mem_addr[7:0];
  assign wr      = hit & bus.mem_we;
  assign push    = wr && (off == 8'h00);
  assign stat_wr = wr && (off == 8'h04);
  assign ack_wr  = wr && (off == 8'h10);
  assign cyc_wr  = wr && (off == 8'h14);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = !empty & bus.tx_ready;
  // Acceptance looks only at the start-of-cycle count, so a full FIFO drops
  // the push even when a pop frees a slot in the same cycle.
  assign push_ok = push & !full;
  // Capture uses the pre-edge ready; an ACK in the same cycle cannot let a word in.
  assign capture = bus.rx_valid & !in_valid_q;
  assign cnt8    = 8'(count_q);

  always_comb begin
    wptr_d     = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d      = ovf_q;
    if (stat_wr)        ovf_d = 1'b0;
    if (push && full)   ovf_d = 1'b1;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    if (ack_wr)         in_valid_d = 1'b0;
    if (capture) begin
      in_valid_d = 1'b1;
      in_data_d  = bus.rx_data;
    end
    cycle_d    = cyc_wr ? 32'd0 : cycle_q + 32'd1;
  end

  always_comb begin
    rd_data = '0;
    case (off)
      8'h04:   rd_data = {16'h0, cnt8, 5'h0, ovf_q, empty, !full};
      8'h08:   rd_data = in_data_q;
      8'h0C:   rd_data = {31'h0, in_valid_q};
      8'h14:   rd_data = cycle_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      cycle_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
      cycle_q    <= cycle_d;
    end
  end

  // Storage needs no reset: the count gates every observable entry.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q] <= bus.mem_din[7:0];
  end

  assign bus.tx_data  = fifo_q[rptr_q];
  assign bus.tx_valid = !empty;
  assign bus.rx_ready = !in_valid_q;
  assign bus.dm_addr  = bus.mem_addr[DM_AW+1:2];
  assign bus.dm_we    = bus.mem_we & !hit;
  assign bus.dm_din   = bus.mem_din;
  assign bus.mem_dout = hit ? rd_data : bus.dm_dout;
endmodule
